// File: rtl/cpu_pkg.sv
// Shared types for the control pipeline: decoded control bundle, stage register and select encodings.
// The CTRL_PIPE_FORWARDING_EN macro, read by the pipeline files, selects the forwarding build.
package cpu_pkg;

  localparam int RA_W = 5;

  typedef struct packed {
    logic       alu_src_sel;
    logic [3:0] alu_op;
    logic       reg_file_wr_en;
    logic [1:0] wb_result_sel;
    logic       mem_wr_en;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic [RA_W-1:0]  rd;
  } stage_t;

  // Producer-to-consumer dependency; x0 is never a real destination.
  function automatic logic raw_match(input logic use_rs, input logic [RA_W-1:0] rs,
                                     input logic prod_wr, input logic [RA_W-1:0] prod_rd);
    return use_rs && prod_wr && (prod_rd != '0) && (rs == prod_rd);
  endfunction

endpackage

// File: rtl/cpu_ctrl_pipeline_if.sv
// Bundle between the data path (master) and the control pipeline (slave).
// Build option CTRL_PIPE_FORWARDING_EN does not change this interface.
interface cpu_ctrl_pipeline_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) ();
    import cpu_pkg::*;

    // Flow control: the ID inputs are consumed on a rising edge only while o_stall_id is low or
    // o_flush_id is high; while o_stall_id is high the data path must hold PC and IF/ID unchanged.
    logic                      i_id_valid;
    ctrl_t                     i_id_ctrl;
    logic [REG_ADDR_WIDTH-1:0] i_id_rs1;
    logic [REG_ADDR_WIDTH-1:0] i_id_rs2;
    logic [REG_ADDR_WIDTH-1:0] i_id_rd;
    logic                      i_id_uses_rs1;
    logic                      i_id_uses_rs2;
    logic                      i_ex_pc_src_sel;

    ctrl_t                     o_ex_ctrl;
    ctrl_t                     o_mem_ctrl;
    ctrl_t                     o_wb_ctrl;
    logic [REG_ADDR_WIDTH-1:0] o_ex_rd;
    logic [REG_ADDR_WIDTH-1:0] o_mem_rd;
    logic [REG_ADDR_WIDTH-1:0] o_wb_rd;
    logic                      o_stall_if;
    logic                      o_stall_id;
    logic                      o_flush_id;
    logic [1:0]                o_fwd_a_sel;
    logic [1:0]                o_fwd_b_sel;
    logic [CNT_WIDTH-1:0]      o_stall_count;

    modport master (
        output i_id_valid, i_id_ctrl, i_id_rs1, i_id_rs2, i_id_rd,
               i_id_uses_rs1, i_id_uses_rs2, i_ex_pc_src_sel,
        input  o_ex_ctrl, o_mem_ctrl, o_wb_ctrl, o_ex_rd, o_mem_rd, o_wb_rd,
               o_stall_if, o_stall_id, o_flush_id, o_fwd_a_sel, o_fwd_b_sel, o_stall_count
    );

    modport slave (
        input  i_id_valid, i_id_ctrl, i_id_rs1, i_id_rs2, i_id_rd,
               i_id_uses_rs1, i_id_uses_rs2, i_ex_pc_src_sel,
        output o_ex_ctrl, o_mem_ctrl, o_wb_ctrl, o_ex_rd, o_mem_rd, o_wb_rd,
               o_stall_if, o_stall_id, o_flush_id, o_fwd_a_sel, o_fwd_b_sel, o_stall_count
    );

endinterface

// File: rtl/cpu_ctrl_pipeline_hazard_detect.sv
// Combinational RAW, stall, flush and forwarding-select logic for the control pipeline.
// CTRL_PIPE_FORWARDING_EN: forward from MEM/WB and stall only on load-use; otherwise stall on any RAW.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            ex_valid,
    input  logic            ex_pc_src_sel,
    input  logic            ex_wr,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            mem_wr,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_wr,
    input  logic [RA_W-1:0] wb_rd,
`ifdef CTRL_PIPE_FORWARDING_EN
    input  logic            ex_load,
    input  logic            mem_load,
    input  logic [RA_W-1:0] ex_rs1,
    input  logic [RA_W-1:0] ex_rs2,
    input  logic            ex_uses_rs1,
    input  logic            ex_uses_rs2,
`endif
    output logic            stall,
    output logic            flush,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel
);

    logic id_raw_ex;
    logic hazard;

    assign flush     = ex_pc_src_sel && ex_valid;
    assign id_raw_ex = id_valid && (raw_match(id_uses_rs1, id_rs1, ex_wr, ex_rd) ||
                                    raw_match(id_uses_rs2, id_rs2, ex_wr, ex_rd));

`ifdef CTRL_PIPE_FORWARDING_EN
    assign hazard = id_raw_ex && ex_load;

    // A MEM-stage load has no data yet, so it is never a MEM forwarding source.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (raw_match(ex_uses_rs1, ex_rs1, mem_wr && !mem_load, mem_rd)) fwd_a_sel = FWD_MEM;
        else if (raw_match(ex_uses_rs1, ex_rs1, wb_wr, wb_rd))           fwd_a_sel = FWD_WB;
        if (raw_match(ex_uses_rs2, ex_rs2, mem_wr && !mem_load, mem_rd)) fwd_b_sel = FWD_MEM;
        else if (raw_match(ex_uses_rs2, ex_rs2, wb_wr, wb_rd))           fwd_b_sel = FWD_WB;
    end
`else
    logic id_raw_mem;
    logic id_raw_wb;

    assign id_raw_mem = id_valid && (raw_match(id_uses_rs1, id_rs1, mem_wr, mem_rd) ||
                                     raw_match(id_uses_rs2, id_rs2, mem_wr, mem_rd));
    assign id_raw_wb  = id_valid && (raw_match(id_uses_rs1, id_rs1, wb_wr, wb_rd) ||
                                     raw_match(id_uses_rs2, id_rs2, wb_wr, wb_rd));
    assign hazard     = id_raw_ex || id_raw_mem || id_raw_wb;
    assign fwd_a_sel  = FWD_RF;
    assign fwd_b_sel  = FWD_RF;
`endif

    // The redirect wins: a stale instruction in ID must not hold the front end.
    assign stall = hazard && !flush;

endmodule

// File: rtl/cpu_ctrl_pipeline.sv
// Control-signal pipeline (ID/EX, EX/MEM, MEM/WB) with hazard unit and saturating stall counter.
// CTRL_PIPE_FORWARDING_EN enables operand forwarding; undefined builds stall on every RAW.
module cpu_ctrl_pipeline #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    cpu_ctrl_pipeline_if.slave  bus
);
    import cpu_pkg::*;

    stage_t               ex_q, mem_q, wb_q, ex_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic                 stall, flush, take_id;

    assign take_id = !stall && !flush && bus.i_id_valid;

    always_comb begin
        ex_d = '0;
        if (take_id) ex_d = '{valid: 1'b1, ctrl: bus.i_id_ctrl, rd: RA_W'(bus.i_id_rd)};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

`ifdef CTRL_PIPE_FORWARDING_EN
    // Operand addresses ride along in ID/EX so forwarding can compare against MEM and WB.
    logic [RA_W-1:0] ex_rs1_q, ex_rs2_q;
    logic            ex_uses_rs1_q, ex_uses_rs2_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || !take_id) begin
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_uses_rs1_q <= 1'b0;
            ex_uses_rs2_q <= 1'b0;
        end else begin
            ex_rs1_q      <= RA_W'(bus.i_id_rs1);
            ex_rs2_q      <= RA_W'(bus.i_id_rs2);
            ex_uses_rs1_q <= bus.i_id_uses_rs1;
            ex_uses_rs2_q <= bus.i_id_uses_rs2;
        end
    end
`endif

    hazard_detect u_hazard_detect (
        .id_valid      (bus.i_id_valid),
        .id_rs1        (RA_W'(bus.i_id_rs1)),
        .id_rs2        (RA_W'(bus.i_id_rs2)),
        .id_uses_rs1   (bus.i_id_uses_rs1),
        .id_uses_rs2   (bus.i_id_uses_rs2),
        .ex_valid      (ex_q.valid),
        .ex_pc_src_sel (bus.i_ex_pc_src_sel),
        .ex_wr         (ex_q.valid && ex_q.ctrl.reg_file_wr_en),
        .ex_rd         (ex_q.rd),
        .mem_wr        (mem_q.valid && mem_q.ctrl.reg_file_wr_en),
        .mem_rd        (mem_q.rd),
        .wb_wr         (wb_q.valid && wb_q.ctrl.reg_file_wr_en),
        .wb_rd         (wb_q.rd),
`ifdef CTRL_PIPE_FORWARDING_EN
        .ex_load       (ex_q.ctrl.wb_result_sel == WB_LOAD),
        .mem_load      (mem_q.ctrl.wb_result_sel == WB_LOAD),
        .ex_rs1        (ex_rs1_q),
        .ex_rs2        (ex_rs2_q),
        .ex_uses_rs1   (ex_uses_rs1_q),
        .ex_uses_rs2   (ex_uses_rs2_q),
`endif
        .stall         (stall),
        .flush         (flush),
        .fwd_a_sel     (bus.o_fwd_a_sel),
        .fwd_b_sel     (bus.o_fwd_b_sel)
    );

    assign bus.o_ex_ctrl     = ex_q.valid  ? ex_q.ctrl  : '0;
    assign bus.o_mem_ctrl    = mem_q.valid ? mem_q.ctrl : '0;
    assign bus.o_wb_ctrl     = wb_q.valid  ? wb_q.ctrl  : '0;
    assign bus.o_ex_rd       = ex_q.valid  ? REG_ADDR_WIDTH'(ex_q.rd)  : '0;
    assign bus.o_mem_rd      = mem_q.valid ? REG_ADDR_WIDTH'(mem_q.rd) : '0;
    assign bus.o_wb_rd       = wb_q.valid  ? REG_ADDR_WIDTH'(wb_q.rd)  : '0;
    assign bus.o_stall_if    = stall;
    assign bus.o_stall_id    = stall;
    assign bus.o_flush_id    = flush;
    assign bus.o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_pipeline.sv
// Directed bench for cpu_ctrl_pipeline; expectations follow CTRL_PIPE_FORWARDING_EN when defined.
module tb_cpu_ctrl_pipeline;
  import cpu_pkg::*;

  localparam ctrl_t C_ALU  = '{1'b0, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t C_SUB  = '{1'b0, 4'h1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t C_LOAD = '{1'b1, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_count = 4'd0;

  always #5 clk = ~clk;

  cpu_ctrl_pipeline_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) bus ();

  cpu_ctrl_pipeline #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input ctrl_t c, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2);
    bus.i_id_valid    = v;
    bus.i_id_ctrl     = c;
    bus.i_id_rs1      = rs1;
    bus.i_id_rs2      = rs2;
    bus.i_id_rd       = rd;
    bus.i_id_uses_rs1 = u1;
    bus.i_id_uses_rs2 = u2;
    #1;
  endtask

  task automatic idle_id();
    drive_id(1'b0, '0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle_id();
    repeat (4) tick();
  endtask

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_ex_pc_src_sel = 1'($urandom_range(0, 1));
    drive_id(1'b1, ctrl_t'($urandom_range(0, 2047)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 1'b1, 1'b1);
    tick();
    tick();
    checks++; if ({bus.o_ex_ctrl, bus.o_mem_ctrl, bus.o_wb_ctrl} !== '0) begin errors++;
      $display("FAIL rst_ctrl: got %0h %0h %0h expected 0 0 0", bus.o_ex_ctrl, bus.o_mem_ctrl, bus.o_wb_ctrl); end
    checks++; if ({bus.o_ex_rd, bus.o_mem_rd, bus.o_wb_rd} !== 15'd0) begin errors++;
      $display("FAIL rst_rd: got %0d %0d %0d expected 0 0 0", bus.o_ex_rd, bus.o_mem_rd, bus.o_wb_rd); end
    checks++; if ({bus.o_stall_if, bus.o_stall_id, bus.o_flush_id} !== 3'b000) begin errors++;
      $display("FAIL rst_stall_flush: got %b expected 000", {bus.o_stall_if, bus.o_stall_id, bus.o_flush_id}); end
    checks++; if ({bus.o_fwd_a_sel, bus.o_fwd_b_sel} !== 4'b0000) begin errors++;
      $display("FAIL rst_fwd: got %b expected 0000", {bus.o_fwd_a_sel, bus.o_fwd_b_sel}); end
    checks++; if (bus.o_stall_count !== 4'd0) begin errors++;
      $display("FAIL rst_count: got %0d expected 0", bus.o_stall_count); end
    rst = 1'b0;
    bus.i_ex_pc_src_sel = 1'b0;
    idle_id();
    tick();
  endtask

  task automatic test_alu_back_to_back();
    drive_id(1'b1, C_ALU, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    checks++; if (bus.o_stall_id !== 1'b0) begin errors++;
      $display("FAIL b2b_first_stall: got %b expected 0", bus.o_stall_id); end
    tick();
    checks++; if (bus.o_ex_ctrl !== C_ALU || bus.o_ex_rd !== 5'd5) begin errors++;
      $display("FAIL b2b_ex_stage: got %0h/%0d expected %0h/5", bus.o_ex_ctrl, bus.o_ex_rd, C_ALU); end
    drive_id(1'b1, C_SUB, 5'd5, 5'd3, 5'd7, 1'b1, 1'b1);
`ifdef CTRL_PIPE_FORWARDING_EN
    checks++; if (bus.o_stall_id !== 1'b0) begin errors++;
      $display("FAIL b2b_no_stall: got %b expected 0", bus.o_stall_id); end
    tick();
    checks++; if (bus.o_ex_rd !== 5'd7 || bus.o_mem_rd !== 5'd5) begin errors++;
      $display("FAIL b2b_advance: got ex %0d mem %0d expected 7 5", bus.o_ex_rd, bus.o_mem_rd); end
    checks++; if (bus.o_fwd_a_sel !== 2'b10 || bus.o_fwd_b_sel !== 2'b00) begin errors++;
      $display("FAIL b2b_fwd: got a %b b %b expected 10 00", bus.o_fwd_a_sel, bus.o_fwd_b_sel); end
`else
    checks++; if ({bus.o_stall_if, bus.o_stall_id} !== 2'b11) begin errors++;
      $display("FAIL b2b_stall1: got %b expected 11", {bus.o_stall_if, bus.o_stall_id}); end
    tick();
    checks++; if (bus.o_ex_ctrl !== '0 || bus.o_mem_rd !== 5'd5 || bus.o_stall_id !== 1'b1) begin errors++;
      $display("FAIL b2b_stall2: got ex %0h mem_rd %0d stall %b expected 0 5 1", bus.o_ex_ctrl, bus.o_mem_rd, bus.o_stall_id); end
    tick();
    checks++; if (bus.o_wb_rd !== 5'd5 || bus.o_stall_id !== 1'b1) begin errors++;
      $display("FAIL b2b_stall3: got wb_rd %0d stall %b expected 5 1", bus.o_wb_rd, bus.o_stall_id); end
    tick();
    exp_count = 4'd3;
    checks++; if (bus.o_stall_id !== 1'b0 || bus.o_stall_count !== exp_count) begin errors++;
      $display("FAIL b2b_release: got stall %b count %0d expected 0 %0d", bus.o_stall_id, bus.o_stall_count, exp_count); end
    tick();
    checks++; if (bus.o_ex_rd !== 5'd7 || bus.o_fwd_a_sel !== 2'b00) begin errors++;
      $display("FAIL b2b_proceed: got ex_rd %0d fwd_a %b expected 7 00", bus.o_ex_rd, bus.o_fwd_a_sel); end
`endif
    checks++; if (bus.o_stall_count !== exp_count) begin errors++;
      $display("FAIL b2b_count: got %0d expected %0d", bus.o_stall_count, exp_count); end
    drain();
  endtask

  task automatic test_load_use();
    drive_id(1'b1, C_LOAD, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, C_ALU, 5'd2, 5'd6, 5'd8, 1'b1, 1'b1);
    checks++; if ({bus.o_stall_if, bus.o_stall_id, bus.o_flush_id} !== 3'b110) begin errors++;
      $display("FAIL lu_stall: got %b expected 110", {bus.o_stall_if, bus.o_stall_id, bus.o_flush_id}); end
    tick();
    checks++; if (bus.o_ex_ctrl !== '0 || bus.o_mem_ctrl !== C_LOAD) begin errors++;
      $display("FAIL lu_bubble: got ex %0h mem %0h expected 0 %0h", bus.o_ex_ctrl, bus.o_mem_ctrl, C_LOAD); end
`ifdef CTRL_PIPE_FORWARDING_EN
    exp_count = sat_inc(exp_count);
    checks++; if (bus.o_stall_id !== 1'b0 || bus.o_stall_count !== exp_count) begin errors++;
      $display("FAIL lu_one_cycle: got stall %b count %0d expected 0 %0d", bus.o_stall_id, bus.o_stall_count, exp_count); end
    tick();
    checks++; if (bus.o_ex_rd !== 5'd8 || bus.o_fwd_b_sel !== 2'b01 || bus.o_fwd_a_sel !== 2'b00) begin errors++;
      $display("FAIL lu_fwd: got ex_rd %0d b %b a %b expected 8 01 00", bus.o_ex_rd, bus.o_fwd_b_sel, bus.o_fwd_a_sel); end
`else
    checks++; if (bus.o_stall_id !== 1'b1) begin errors++;
      $display("FAIL lu_stall2: got %b expected 1", bus.o_stall_id); end
    tick();
    checks++; if (bus.o_stall_id !== 1'b1 || bus.o_wb_ctrl !== C_LOAD) begin errors++;
      $display("FAIL lu_stall3: got stall %b wb %0h expected 1 %0h", bus.o_stall_id, bus.o_wb_ctrl, C_LOAD); end
    tick();
    exp_count = exp_count + 4'd3;
    checks++; if (bus.o_stall_id !== 1'b0 || bus.o_stall_count !== exp_count) begin errors++;
      $display("FAIL lu_release: got stall %b count %0d expected 0 %0d", bus.o_stall_id, bus.o_stall_count, exp_count); end
    tick();
    checks++; if (bus.o_ex_rd !== 5'd8 || bus.o_fwd_b_sel !== 2'b00) begin errors++;
      $display("FAIL lu_proceed: got ex_rd %0d fwd_b %b expected 8 00", bus.o_ex_rd, bus.o_fwd_b_sel); end
`endif
    drain();
  endtask

  task automatic test_x0_dest();
    drive_id(1'b1, C_ALU, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, C_ALU, 5'd0, 5'd3, 5'd9, 1'b1, 1'b1);
    checks++; if (bus.o_stall_id !== 1'b0) begin errors++;
      $display("FAIL x0_no_stall: got %b expected 0", bus.o_stall_id); end
    tick();
    checks++; if (bus.o_ex_rd !== 5'd9 || bus.o_fwd_a_sel !== 2'b00) begin errors++;
      $display("FAIL x0_fwd: got ex_rd %0d fwd_a %b expected 9 00", bus.o_ex_rd, bus.o_fwd_a_sel); end
    checks++; if (bus.o_stall_count !== exp_count) begin errors++;
      $display("FAIL x0_count: got %0d expected %0d", bus.o_stall_count, exp_count); end
    drain();
  endtask

  task automatic test_branch_load_use();
    drive_id(1'b1, C_LOAD, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0);
    tick();
    bus.i_ex_pc_src_sel = 1'b1;
    drive_id(1'b1, C_ALU, 5'd2, 5'd6, 5'd8, 1'b1, 1'b1);
    checks++; if ({bus.o_flush_id, bus.o_stall_if, bus.o_stall_id} !== 3'b100) begin errors++;
      $display("FAIL br_priority: got flush/stall_if/stall_id %b expected 100", {bus.o_flush_id, bus.o_stall_if, bus.o_stall_id}); end
    tick();
    checks++; if (bus.o_ex_ctrl !== '0 || bus.o_ex_rd !== 5'd0 || bus.o_mem_ctrl !== C_LOAD) begin errors++;
      $display("FAIL br_bubble: got ex %0h rd %0d mem %0h expected 0 0 %0h", bus.o_ex_ctrl, bus.o_ex_rd, bus.o_mem_ctrl, C_LOAD); end
    checks++; if (bus.o_flush_id !== 1'b0 || bus.o_stall_count !== exp_count) begin errors++;
      $display("FAIL br_after: got flush %b count %0d expected 0 %0d", bus.o_flush_id, bus.o_stall_count, exp_count); end
    bus.i_ex_pc_src_sel = 1'b0;
    drain();
  endtask

  task automatic test_stall_chain();
`ifdef CTRL_PIPE_FORWARDING_EN
    ctrl_t c = C_LOAD;
    int links = 20;
    int per = 1;
`else
    ctrl_t c = C_ALU;
    int links = 7;
    int per = 3;
`endif
    drive_id(1'b1, c, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < links; k++) begin
      for (int s = 0; s < per; s++) begin
        checks++; if (bus.o_stall_id !== 1'b1) begin errors++;
          $display("FAIL chain_stall[%0d.%0d]: got %b expected 1", k, s, bus.o_stall_id); end
        tick();
        exp_count = sat_inc(exp_count);
      end
      checks++; if (bus.o_stall_id !== 1'b0 || bus.o_stall_count !== exp_count) begin errors++;
        $display("FAIL chain_release[%0d]: got stall %b count %0d expected 0 %0d", k, bus.o_stall_id, bus.o_stall_count, exp_count); end
      tick();
    end
    checks++; if (bus.o_stall_count !== 4'd15) begin errors++;
      $display("FAIL chain_saturate: got %0d expected 15", bus.o_stall_count); end
    drain();
  endtask

  task automatic test_reset_mid();
    drive_id(1'b1, C_ALU, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, C_SUB, 5'd1, 5'd3, 5'd7, 1'b1, 1'b1);
    tick();
    checks++; if (bus.o_ex_rd !== 5'd7 || bus.o_mem_rd !== 5'd5) begin errors++;
      $display("FAIL mid_loaded: got ex %0d mem %0d expected 7 5", bus.o_ex_rd, bus.o_mem_rd); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.o_ex_ctrl, bus.o_mem_ctrl, bus.o_wb_ctrl} !== '0 || bus.o_stall_count !== 4'd0) begin errors++;
      $display("FAIL mid_reset: got %0h %0h %0h count %0d expected 0 0 0 0", bus.o_ex_ctrl, bus.o_mem_ctrl, bus.o_wb_ctrl, bus.o_stall_count); end
    rst = 1'b0;
    idle_id();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_x0_dest();
    test_branch_load_use();
    test_stall_chain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_pipeline.md
# cpu_ctrl_pipeline

Control-signal pipeline and hazard unit for the five-stage successor of the single-cycle core (IF, ID, EX, MEM, WB). Takes the per-instruction control bundle that `control_unit` decodes in ID, carries it through ID/EX, EX/MEM and MEM/WB registers, and generates stall, flush and forwarding selects for the data path. A saturating stall-cycle counter supports performance debug. The data path owns all data registers; this block owns only control, register addresses and valid bits.

## Interface
- `REG_ADDR_WIDTH`, 5, register-file address width
- `CNT_WIDTH`, 32, stall-counter width
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_id_valid`  in  1  ID holds a real instruction
- `i_id_ctrl`  in  ctrl_t  decoded control bundle from `control_unit`
- `i_id_rs1`, `i_id_rs2`, `i_id_rd`  in  REG_ADDR_WIDTH each  ID register addresses
- `i_id_uses_rs1`, `i_id_uses_rs2`  in  1 each  operand actually read
- `i_ex_pc_src_sel`  in  1  branch/jump taken, resolved in EX
- `o_ex_ctrl`, `o_mem_ctrl`, `o_wb_ctrl`  out  ctrl_t  registered stage control, zeroed when the stage is invalid
- `o_ex_rd`, `o_mem_rd`, `o_wb_rd`  out  REG_ADDR_WIDTH  destination per stage
- `o_stall_if`, `o_stall_id`  out  1  hold PC and the IF/ID register
- `o_flush_id`  out  1  clear the IF/ID register
- `o_fwd_a_sel`, `o_fwd_b_sel`  out  2  EX operand source: 00 register file, 01 WB, 10 MEM
- `o_stall_count`  out  CNT_WIDTH  stall cycles since reset

## Operation
- ctrl_t fields: alu_src_sel(1), alu_op(4), reg_file_wr_en(1), wb_result_sel(2; 01 = load), mem_wr_en(1), branch(1), jump(1).
- Each stage register holds {valid, ctrl, rd}. Downstream outputs are AND-gated with valid, so an invalid stage never writes memory or the register file.
- A RAW match needs a consumer operand with its use bit set, rs equal to the producer rd, rd ≠ 0, producer valid and producer reg_file_wr_en = 1.
- Load-use: an EX-stage load with a RAW match to ID asserts `o_stall_if` and `o_stall_id`. ID/EX loads a bubble (valid = 0). EX/MEM and MEM/WB advance normally.
- Forwarding is combinational on the EX stage's registered rs1/rs2 (kept in ID/EX). A MEM match selects 10; otherwise a WB match selects 01; otherwise 00. MEM takes priority over WB. A MEM load never forwards from MEM, because load-use already guarantees a one-cycle gap.
- Taken branch (`i_ex_pc_src_sel` = 1 with EX valid): assert `o_flush_id`, and ID/EX loads a bubble. The flush overrides a simultaneous load-use stall: stalls deassert that cycle and the redirected fetch proceeds.
- The stall counter increments on every cycle where `o_stall_id` = 1 and saturates at all-ones.

## Timing
- Reset: all valid bits 0, all ctrl and rd registers 0, and every output 0, including the forwarding selects and the counter. Reset applied mid-operation discards all in-flight instructions on the next edge.
- Latency from ID to EX, MEM and WB is 1, 2 and 3 cycles.
- Stall, flush and forward outputs are combinational from current register state plus ID inputs, and are valid within the same cycle.
- A load-use stall lasts exactly one cycle with forwarding enabled. On the next cycle the load is in MEM and is forwarded from WB a cycle later.
- The ID inputs are sampled only when `o_stall_id` = 0 or a flush is active.

## Configuration
- `CTRL_PIPE_FORWARDING_EN` defined: behaviour as above.
- Undefined: `o_fwd_a_sel` and `o_fwd_b_sel` are tied to 00. Any RAW match from ID against EX, MEM or WB stalls IF and ID and inserts a bubble, up to three cycles per dependency. The flush priority is unchanged.

## Structure
- `cpu_pkg` holds ctrl_t, the wb_result_sel encodings, the forwarding-select encodings, and the stage-register struct {valid, ctrl, rd}.
- One sub-module, `hazard_detect`, holds the combinational RAW, stall, flush and forwarding logic. The top holds the three stage registers and the counter.

## Test plan
- Reset: assert `i_reset` for 2 cycles with garbage inputs -> all outputs 0, and `o_stall_count` = 0.
- ALU back-to-back: add x5 followed by sub using rs1 = x5 -> `o_fwd_a_sel` = 10 with the sub in EX, and no stall.
- Load-use: lw x6 followed by add using rs2 = x6 -> one stall cycle, EX bubble, then `o_fwd_b_sel` = 01, and count = 1.
- x0 destination: instruction writing x0 followed by a consumer of rs1 = x0 -> `o_fwd_a_sel` = 00, and no stall.
- Branch plus load-use in the same cycle: taken branch in EX while ID meets a load-use condition -> `o_flush_id` = 1, stalls = 0, EX valid = 0 on the next edge.
- Forwarding compiled out: a dependency at distance 1 -> 3 stall cycles, then proceeds; after 2^CNT_WIDTH stall cycles with CNT_WIDTH = 4 the counter holds at 15.
